// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and the
// clog2 helper also used by the fifo block to size its pointers.
package fifo_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ISSUE   = 2'b01;
    localparam logic [1:0] ST_BLOCKED = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        BLOCKED = ST_BLOCKED
    } arb_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request at or above ptr,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Rotating priority search; the first hit from ptr upward wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NREQ]) begin
                gnt[(int'(ptr) + i) % NREQ] = 1'b1;
                idx = PTR_W'((int'(ptr) + i) % NREQ);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO among NREQ requesters.
// Acks are combinational; the FIFO write port is driven from a register
// stage. An internal credit counter mirrors FIFO occupancy so that no
// write is issued to a full FIFO despite the FIFO's late full flag.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*WIDTH-1:0]    data_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [WIDTH-1:0]         fifo_din_o,
    output logic                     fifo_wr_en_o,
    input  logic                     fifo_rd_en_i,
    output logic                     blocked_o,
    output logic [clog2(DEPTH):0]    count_o
);

    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int PTR_W = (NREQ > 1) ? clog2(NREQ) : 1;

    arb_state_e        state_q;
    arb_state_e        state_nxt;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [CNT_W-1:0]  credit_q;
    logic [CNT_W-1:0]  credit_nxt;

    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  win_idx;
    logic              any_req;
    logic              accept;
    logic              rd_take;
    logic [WIDTH-1:0]  win_data_p0;

    logic [WIDTH-1:0]  din_p1;
    logic              vld_p1;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win_idx),
        .any (any_req)
    );

    // ---- stage p0: selection and credit check (combinational) ----
    assign accept      = any_req && (credit_q < CNT_W'(DEPTH));
    assign rd_take     = fifo_rd_en_i && (credit_q != '0);
    assign win_data_p0 = data_i[win_idx*WIDTH +: WIDTH];
    // Held low during reset so no requester sees an ack it cannot use.
    assign ack_o       = (reset_ni && accept) ? gnt : '0;

    // Credit update: accept adds, a real read removes, both cancel out.
    always_comb begin
        credit_nxt = credit_q;
        case ({accept, rd_take})
            2'b10:   credit_nxt = credit_q + CNT_W'(1);
            2'b01:   credit_nxt = credit_q - CNT_W'(1);
            default: credit_nxt = credit_q;
        endcase
    end

    // Pointer moves just past the winner so it has lowest priority next.
    always_comb begin
        ptr_nxt = ptr_q;
        if (accept) begin
            if (win_idx == PTR_W'(NREQ - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = win_idx + PTR_W'(1);
            end
        end
    end

    // Next-state logic: accept beats pending-but-full beats idle.
    always_comb begin
        state_nxt = state_q;
        if (accept) begin
            state_nxt = ISSUE;
        end else if (any_req) begin
            state_nxt = BLOCKED;
        end else begin
            state_nxt = IDLE;
        end
    end

    // Control state: FSM, round-robin pointer and credit counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            credit_q <= credit_nxt;
        end
    end

    // ---- stage p1: registered FIFO write port ----
    // Data only loads on an accept so the FIFO input holds between writes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_p1 <= 1'b0;
            din_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                din_p1 <= win_data_p0;
            end
        end
    end

    assign fifo_wr_en_o = vld_p1;
    assign fifo_din_o   = din_p1;
    assign blocked_o    = (state_q == BLOCKED);
    assign count_o      = credit_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: table of per-cycle vectors plus hand-written
// reset sequences; written words are tracked through a scoreboard queue.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;

    logic                  clk_i;
    logic                  reset_ni;
    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] data_i;
    logic [NREQ-1:0]       ack_o;
    logic [WIDTH-1:0]      fifo_din_o;
    logic                  fifo_wr_en_o;
    logic                  fifo_rd_en_i;
    logic                  blocked_o;
    logic [3:0]            count_o;

    fifo_wr_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req_i        (req_i),
        .data_i       (data_i),
        .ack_o        (ack_o),
        .fifo_din_o   (fifo_din_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_rd_en_i (fifo_rd_en_i),
        .blocked_o    (blocked_o),
        .count_o      (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] req;
        logic       rd;
        logic [3:0] ack;
        logic [3:0] cnt;
        logic       blk;
    } vec_t;

    vec_t           vecs[64];
    int             nv;
    int             checks;
    int             errors;
    logic [7:0]     exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic rd, input logic [3:0] ack,
                       input logic [3:0] cnt, input logic blk);
        vecs[nv].req = req;
        vecs[nv].rd  = rd;
        vecs[nv].ack = ack;
        vecs[nv].cnt = cnt;
        vecs[nv].blk = blk;
        nv++;
    endtask

    task automatic sb_check();
        logic [7:0] w;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("wr_en", 32'(fifo_wr_en_o), 32'd1);
            check("din", 32'(fifo_din_o), 32'(w));
        end else begin
            check("wr_en_idle", 32'(fifo_wr_en_o), 32'd0);
        end
    endtask

    // Called at posedge+1: drive, check ack mid-cycle, check registers after edge.
    task automatic run_vec(input int i);
        logic [NREQ*WIDTH-1:0] d;
        req_i        = vecs[i].req;
        fifo_rd_en_i = vecs[i].rd;
        @(negedge clk_i);
        check($sformatf("ack[%0d]", i), 32'(ack_o), 32'(vecs[i].ack));
        d = data_i;
        for (int k = 0; k < NREQ; k++) begin
            if (vecs[i].ack[k]) exp_q.push_back(d[k*WIDTH +: WIDTH]);
        end
        @(posedge clk_i);
        #1;
        sb_check();
        check($sformatf("count[%0d]", i), 32'(count_o), 32'(vecs[i].cnt));
        check($sformatf("blocked[%0d]", i), 32'(blocked_o), 32'(vecs[i].blk));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack_o), 32'd0);
        check({tag, "_wr_en"}, 32'(fifo_wr_en_o), 32'd0);
        check({tag, "_din"}, 32'(fifo_din_o), 32'd0);
        check({tag, "_blocked"}, 32'(blocked_o), 32'd0);
        check({tag, "_count"}, 32'(count_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        nv     = 0;

        // single write from requester 0
        add(4'b0001, 1'b0, 4'b0001, 4'd1, 1'b0);
        // all four requesting, fill to DEPTH in round-robin order
        add(4'b1111, 1'b0, 4'b0001, 4'd1, 1'b0);
        add(4'b1111, 1'b0, 4'b0010, 4'd2, 1'b0);
        add(4'b1111, 1'b0, 4'b0100, 4'd3, 1'b0);
        add(4'b1111, 1'b0, 4'b1000, 4'd4, 1'b0);
        add(4'b1111, 1'b0, 4'b0001, 4'd5, 1'b0);
        add(4'b1111, 1'b0, 4'b0010, 4'd6, 1'b0);
        add(4'b1111, 1'b0, 4'b0100, 4'd7, 1'b0);
        add(4'b1111, 1'b0, 4'b1000, 4'd8, 1'b0);
        // full: no ack, then one read frees one slot a cycle later
        add(4'b1111, 1'b0, 4'b0000, 4'd8, 1'b1);
        add(4'b1111, 1'b1, 4'b0000, 4'd7, 1'b1);
        add(4'b1111, 1'b0, 4'b0001, 4'd8, 1'b0);
        add(4'b1111, 1'b0, 4'b0000, 4'd8, 1'b1);
        // requests withdrawn without ack, then accept+read at DEPTH-1
        add(4'b0000, 1'b1, 4'b0000, 4'd7, 1'b0);
        add(4'b0100, 1'b1, 4'b0100, 4'd7, 1'b0);
        // drain to empty, then a read on empty
        for (int c = 6; c >= 0; c--) add(4'b0000, 1'b1, 4'b0000, 4'(c), 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0);
        // pointer at 3: wrap to 0, then fairness between two requesters
        add(4'b1001, 1'b0, 4'b1000, 4'd1, 1'b0);
        add(4'b1001, 1'b0, 4'b0001, 4'd2, 1'b0);
        add(4'b0011, 1'b0, 4'b0010, 4'd3, 1'b0);
        add(4'b0011, 1'b0, 4'b0001, 4'd4, 1'b0);
        add(4'b0011, 1'b0, 4'b0010, 4'd5, 1'b0);

        // power-on reset, with requests held high to confirm no ack leaks
        reset_ni     = 1'b0;
        req_i        = 4'b1111;
        fifo_rd_en_i = 1'b0;
        data_i       = {8'h13, 8'h12, 8'h11, 8'hA5};
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("por");
        req_i = 4'b0000;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_all_zero("post_por");

        run_vec(0);

        // reset the cycle after an ack: pending write must vanish at once
        req_i = 4'b1111;
        #2;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        check("mid_rst_din", 32'(fifo_din_o), 32'd0);
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_ack", 32'(ack_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        req_i = 4'b0000;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_all_zero("post_rst");

        data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 1; i < nv; i++) run_vec(i);

        req_i        = 4'b0000;
        fifo_rd_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        sb_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` instance among NREQ requesters in the Lease Cache memory-controller test environment. Requesters post words with a req/ack handshake; the arbiter picks one per cycle and drives the FIFO write port from a registered output stage. It tracks FIFO occupancy with an internal credit counter, so no write is issued to a full FIFO even though the FIFO's `full_o` lags a cycle.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `width`
- `NREQ`, 4, number of requesters, 2..16
- `DEPTH`, 8, FIFO depth, power of two; must match the FIFO `depth`
- `clk_i`  in  1  clock; all logic on the rising edge
- `reset_ni`  in  1  asynchronous, active-low reset
- `req_i`  in  NREQ  per-requester write request; held high until acked
- `data_i`  in  NREQ*WIDTH  requester k's word in bits [k*WIDTH +: WIDTH]; stable while `req_i[k]` is high
- `ack_o`  out  NREQ  one-hot, combinational; `ack_o[k]`=1 means the word is accepted this cycle
- `fifo_din_o`  out  WIDTH  registered write data to the FIFO `din_i`
- `fifo_wr_en_o`  out  1  registered write strobe to the FIFO write enable
- `fifo_rd_en_i`  in  1  copy of the FIFO read enable, used for credit return
- `blocked_o`  out  1  registered; 1 while requests are pending and no credit is available
- `count_o`  out  clog2(DEPTH)+1  registered credit count, equal to FIFO occupancy

## Operation
- Credit counter `count`, range 0..DEPTH:
  - +1 at the edge after an accept.
  - -1 on a cycle with `fifo_rd_en_i`=1 and `count`>0.
  - Both events in the same cycle leave it unchanged.
  - A read with `count`=0 is ignored.
- Accept condition in cycle t: |`req_i` and `count` < DEPTH.
- Winner selection:
  - The winner k is the first set bit of `req_i` searching upward from pointer `ptr`, wrapping from NREQ-1 to 0.
  - Only `ack_o[k]` is asserted.
- At edge t+1:
  - `fifo_din_o` takes `data_i[k]`.
  - `fifo_wr_en_o` goes to 1.
  - `ptr` becomes (k+1) mod NREQ.
- No accept in cycle t means `fifo_wr_en_o`=0 at t+1 and `ptr` is unchanged; `fifo_din_o` holds its last value.
- State machine (registered), states:
  - IDLE: no requests.
  - ISSUE: accept occurred last cycle.
  - BLOCKED: requests pending, `count`==DEPTH.
- Transitions, evaluated each cycle in priority order:
  - Accept → ISSUE.
  - Else |`req_i` (so `count`==DEPTH) → BLOCKED.
  - Else → IDLE.
- `blocked_o` = (state==BLOCKED).
- A requester may deassert `req_i` without an ack; nothing is written for it.
- Requester k's requests are accepted back-to-back only if no other requester is pending: with several pending, each wins at most once per NREQ accepts.

## Timing
- Reset values: `ack_o`=0, `fifo_wr_en_o`=0, `fifo_din_o`=0, `blocked_o`=0, `count_o`=0; state IDLE, `ptr`=0.
- Reset is asynchronous on assertion. Deassertion is sampled at the next rising edge.
- Latency:
  - Request to ack: 0 cycles, when credit is available.
  - Ack to `fifo_wr_en_o`: 1 cycle.
  - Peak throughput: 1 word per cycle.
- Full boundary:
  - With `count`==DEPTH, no ack is given.
  - A read in that cycle frees credit from the next cycle, so the accept comes one cycle later.
- Simultaneous accept and read at `count`==DEPTH-1: accept allowed, `count` stays DEPTH-1.
- Reset mid-operation:
  - A pending registered write is dropped and `fifo_wr_en_o` is forced to 0.
  - The FIFO is reset together with the arbiter, so `count` restarts at 0.
- `ptr` wrap-around: NREQ-1 → 0.

## Structure
- Package `fifo_arb_pkg`:
  - state encoding as localparams: IDLE=2'b00, ISSUE=2'b01, BLOCKED=2'b10
  - `clog2` function shared with `fifo`
- Sub-module `rr_pick`: combinational; inputs `req`[NREQ] and `ptr`; outputs one-hot `gnt`, encoded `idx`, `any`.
- The top level holds `ptr`, `count`, state, and the output registers.

## Test plan
- Reset, then `req_i`=4'b0001, `data_i[0]`=8'hA5 for 1 cycle → `ack_o`=4'b0001 in the same cycle; next cycle `fifo_wr_en_o`=1, `fifo_din_o`=8'hA5, `count_o`=1.
- `req_i`=4'b1111 held, with requester k's data = 8'h10+k, no reads → acks 0,1,2,3,0,1,2,3 on consecutive cycles; FIFO receives 10,11,12,13,10,11,12,13; `count_o` reaches 8.
- Continue holding all requests with `count_o`=8 → `ack_o`=0, `blocked_o`=1; pulse `fifo_rd_en_i` once → exactly one ack one cycle later, and `count_o` is 8 again.
- At `count_o`=7: `req_i`=4'b0100 and `fifo_rd_en_i`=1 in the same cycle → ack granted, `count_o` stays 7.
- `fifo_rd_en_i`=1 with `count_o`=0 → `count_o` stays 0, no underflow.
- Assert `reset_ni`=0 the cycle after an ack → `fifo_wr_en_o` drops immediately (asynchronously); after release all outputs are 0 and the next grant starts from requester 0.
